// File: rtl/conv_dram_scheduler.sv
// conv_dram_scheduler: sequences one conv+maxpool layer pass over the shared DRAM port.
// Pulses param_load, fetches ifmap rows against line-buffer credits, and packs pooled
// 8-bit pixels into 64-bit words for write-back. Writes take the port ahead of reads.
//
// Handshake: every strobe here is a plain valid with no back-pressure. A row_req pulse
// grants one row of line-buffer space. A pool_valid pulse hands over one pixel that must
// be taken that cycle. DRAMreadEn/DRAMwriteEn are fire-and-forget commands. Read data
// returns exactly one cycle after DRAMreadEn, and ifmap_valid/ifmap_word_idx mark it.
module conv_dram_scheduler #(
    parameter int ADDR_W     = 10,
    parameter int ROWS       = 28,
    parameter int ROW_WORDS  = 4,
    parameter int IFMAP_BASE = 0,
    parameter int OUT_BASE   = 0,
    parameter int NUM_POOL   = 196
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              param_load,
    input  logic              row_req,
    output logic              ifmap_valid,
    output logic [1:0]        ifmap_word_idx,
    input  logic              pool_valid,
    input  logic [7:0]        pool_data,
    output logic              DRAMreadEn,
    output logic [ADDR_W-1:0] DRAMreadAddr,
    output logic              DRAMwriteEn,
    output logic [ADDR_W-1:0] DRAMwriteAddr,
    output logic [63:0]       DRAMwriteData
);

    localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int WORD_W = (ROW_WORDS > 1) ? $clog2(ROW_WORDS) : 1;
    localparam int PIX_W  = $clog2(NUM_POOL + 1);

    localparam logic [ROW_W-1:0]  LAST_ROW   = ROW_W'(ROWS - 1);
    localparam logic [WORD_W-1:0] LAST_WORD  = WORD_W'(ROW_WORDS - 1);
    localparam logic [PIX_W-1:0]  POOL_TOTAL = PIX_W'(NUM_POOL);
    localparam logic [PIX_W-1:0]  POOL_LAST  = PIX_W'(NUM_POOL - 1);
    localparam logic [ADDR_W-1:0] IF_BASE_A  = ADDR_W'(IFMAP_BASE);
    localparam logic [ADDR_W-1:0] OUT_BASE_A = ADDR_W'(OUT_BASE);
    localparam logic [ADDR_W-1:0] ROW_W_A    = ADDR_W'(ROW_WORDS);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_WAIT_ROW, S_READ_ROW, S_DRAIN, S_DONE
    } state_t;

    state_t              state;
    logic [1:0]          credit;
    logic [ROW_W-1:0]    row;
    logic [WORD_W-1:0]   word;
    logic [2:0]          byte_cnt;
    logic [PIX_W-1:0]    pix_cnt;
    logic [ADDR_W-1:0]   wcnt;
    logic [63:0]         pack;
    logic [63:0]         pack_next;
    logic                pend_valid;
    logic [63:0]         pend_data;

    logic                start_ok;
    logic                rd_fire;
    logic                pix_ok;
    logic                word_full;
    logic                credit_inc;
    logic                credit_dec;
    logic [ADDR_W-1:0]   rd_addr;

    assign start_ok   = start && (state == S_IDLE);
    // A pending write owns the port this cycle; the read simply retries next cycle.
    assign rd_fire    = (state == S_READ_ROW) && !pend_valid;
    assign pix_ok     = pool_valid && (pix_cnt != POOL_TOTAL) &&
                        (state == S_WAIT_ROW || state == S_READ_ROW || state == S_DRAIN);
    assign word_full  = (byte_cnt == 3'd7) || (pix_cnt == POOL_LAST);
    assign credit_inc = row_req && (state != S_IDLE);
    assign credit_dec = (state == S_WAIT_ROW) && (credit != 2'd0);
    assign rd_addr    = IF_BASE_A + ADDR_W'(row) * ROW_W_A + ADDR_W'(word);

    assign DRAMreadEn    = rd_fire;
    assign DRAMreadAddr  = rd_fire ? rd_addr : '0;
    assign DRAMwriteEn   = pend_valid;
    assign DRAMwriteAddr = pend_valid ? (OUT_BASE_A + wcnt) : '0;
    assign DRAMwriteData = pend_valid ? pend_data : '0;

    // Drop the incoming pixel into its byte lane of the word being assembled.
    always_comb begin
        pack_next = pack;
        pack_next[{byte_cnt, 3'b000} +: 8] = pool_data;
    end

    // Pass sequencer: parameter load, row fetch walk, drain, done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            param_load     <= 1'b0;
            ifmap_valid    <= 1'b0;
            ifmap_word_idx <= 2'd0;
            row            <= '0;
            word           <= '0;
        end else begin
            param_load     <= 1'b0;
            done           <= 1'b0;
            ifmap_valid    <= rd_fire;
            ifmap_word_idx <= rd_fire ? 2'(word) : 2'd0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_LOAD;
                        busy       <= 1'b1;
                        param_load <= 1'b1;
                        row        <= '0;
                        word       <= '0;
                    end
                end
                S_LOAD:     state <= S_WAIT_ROW;
                S_WAIT_ROW: if (credit != 2'd0) state <= S_READ_ROW;
                S_READ_ROW: begin
                    if (rd_fire) begin
                        if (word == LAST_WORD) begin
                            word <= '0;
                            if (row == LAST_ROW) begin
                                state <= S_DRAIN;
                            end else begin
                                row   <= row + ROW_W'(1);
                                state <= S_WAIT_ROW;
                            end
                        end else begin
                            word <= word + WORD_W'(1);
                        end
                    end
                end
                // With every pixel counted, the last word is either already written or
                // being written this very cycle, so done lands one cycle after it.
                S_DRAIN: begin
                    if (pix_cnt == POOL_TOTAL) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Line-buffer credits: saturating at 3, grant and row start in one cycle cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit <= 2'd0;
        end else if (start_ok) begin
            credit <= 2'd0;
        end else if (credit_inc && !credit_dec) begin
            if (credit != 2'd3) credit <= credit + 2'd1;
        end else if (credit_dec && !credit_inc) begin
            credit <= credit - 2'd1;
        end
    end

    // Pixel packer and single-entry write buffer, independent of the read walk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt   <= 3'd0;
            pix_cnt    <= '0;
            wcnt       <= '0;
            pack       <= '0;
            pend_valid <= 1'b0;
            pend_data  <= '0;
        end else if (start_ok) begin
            byte_cnt   <= 3'd0;
            pix_cnt    <= '0;
            wcnt       <= '0;
            pack       <= '0;
            pend_valid <= 1'b0;
            pend_data  <= '0;
        end else begin
            if (pend_valid) begin
                wcnt       <= wcnt + ADDR_W'(1);
                pend_valid <= 1'b0;
            end
            if (pix_ok) begin
                pix_cnt <= pix_cnt + PIX_W'(1);
                if (word_full) begin
                    pend_data  <= pack_next;
                    pend_valid <= 1'b1;
                    pack       <= '0;
                    byte_cnt   <= 3'd0;
                end else begin
                    pack     <= pack_next;
                    byte_cnt <= byte_cnt + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_dram_scheduler.sv
// Bench for conv_dram_scheduler: directed passes with a scoreboard of expected DRAM
// reads and writes, checked by a monitor on the falling clock edge.
module tb_conv_dram_scheduler;

  localparam int ADDR_W = 10;

  logic              clk;
  logic              rst;
  logic              start;
  logic              busy;
  logic              done;
  logic              param_load;
  logic              row_req;
  logic              ifmap_valid;
  logic [1:0]        ifmap_word_idx;
  logic              pool_valid;
  logic [7:0]        pool_data;
  logic              DRAMreadEn;
  logic [ADDR_W-1:0] DRAMreadAddr;
  logic              DRAMwriteEn;
  logic [ADDR_W-1:0] DRAMwriteAddr;
  logic [63:0]       DRAMwriteData;

  conv_dram_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .param_load(param_load), .row_req(row_req), .ifmap_valid(ifmap_valid),
    .ifmap_word_idx(ifmap_word_idx), .pool_valid(pool_valid), .pool_data(pool_data),
    .DRAMreadEn(DRAMreadEn), .DRAMreadAddr(DRAMreadAddr), .DRAMwriteEn(DRAMwriteEn),
    .DRAMwriteAddr(DRAMwriteAddr), .DRAMwriteData(DRAMwriteData)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [ADDR_W-1:0] exp_rd_q[$];
  logic [ADDR_W-1:0] exp_wa_q[$];
  logic [63:0]       exp_wd_q[$];

  int rd_cnt = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int pl_cnt = 0;
  int wr_overlap = 0;
  logic [63:0] word0 = '0;
  logic [63:0] word24 = '0;
  logic prev_rd = 1'b0;
  logic [1:0] prev_idx = 2'd0;
  logic prev_wr = 1'b0;
  logic [ADDR_W-1:0] prev_wa = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name, input logic [63:0] act);
    checks++;
    failures++;
    $display("FAIL %s: got 0x%0h with nothing expected", name, act);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rd(input logic [ADDR_W-1:0] addr, input int budget);
    int n = 0;
    logic found = 1'b0;
    while (!found && n < budget) begin
      @(negedge clk);
      if (DRAMreadEn && DRAMreadAddr == addr) found = 1'b1;
      n++;
    end
    chk("read_seen", {63'd0, found}, 64'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_done"}, {63'd0, done}, 64'd0);
    chk({tag, "_param_load"}, {63'd0, param_load}, 64'd0);
    chk({tag, "_ifmap_valid"}, {63'd0, ifmap_valid}, 64'd0);
    chk({tag, "_ifmap_idx"}, {62'd0, ifmap_word_idx}, 64'd0);
    chk({tag, "_rd_en"}, {63'd0, DRAMreadEn}, 64'd0);
    chk({tag, "_rd_addr"}, {54'd0, DRAMreadAddr}, 64'd0);
    chk({tag, "_wr_en"}, {63'd0, DRAMwriteEn}, 64'd0);
    chk({tag, "_wr_addr"}, {54'd0, DRAMwriteAddr}, 64'd0);
    chk({tag, "_wr_data"}, DRAMwriteData, 64'd0);
  endtask

  task automatic pulse_start_and_check();
    tick();
    start = 1'b1;
    @(negedge clk);
    chk("param_load_before", {63'd0, param_load}, 64'd0);
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("param_load_pulse", {63'd0, param_load}, 64'd1);
    chk("busy_after_start", {63'd0, busy}, 64'd1);
    @(negedge clk);
    chk("param_load_one_cycle", {63'd0, param_load}, 64'd0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst) begin
      prev_rd = 1'b0;
      prev_idx = 2'd0;
      prev_wr = 1'b0;
      prev_wa = '0;
    end else begin
      if (prev_rd || ifmap_valid) begin
        chk("ifmap_valid_latency", {63'd0, ifmap_valid}, {63'd0, prev_rd});
        if (prev_rd) chk("ifmap_word_idx", {62'd0, ifmap_word_idx}, {62'd0, prev_idx});
      end
      if (DRAMreadEn) begin
        rd_cnt++;
        if (exp_rd_q.size() == 0) fail_event("read_unexpected", {54'd0, DRAMreadAddr});
        else chk("read_addr", {54'd0, DRAMreadAddr}, {54'd0, exp_rd_q.pop_front()});
      end
      if (DRAMwriteEn) begin
        wr_cnt++;
        chk("write_blocks_read", {63'd0, DRAMreadEn}, 64'd0);
        if (exp_rd_q.size() != 0) wr_overlap++;
        if (exp_wa_q.size() == 0) begin
          fail_event("write_unexpected", {54'd0, DRAMwriteAddr});
        end else begin
          chk("write_addr", {54'd0, DRAMwriteAddr}, {54'd0, exp_wa_q.pop_front()});
          chk("write_data", DRAMwriteData, exp_wd_q.pop_front());
        end
        if (DRAMwriteAddr == 10'd0) word0 = DRAMwriteData;
        if (DRAMwriteAddr == 10'd24) word24 = DRAMwriteData;
      end
      if (done) begin
        done_cnt++;
        chk("done_after_last_write", {53'd0, prev_wr, prev_wa}, {53'd0, 1'b1, 10'd24});
      end
      if (param_load) pl_cnt++;
      prev_rd = DRAMreadEn;
      prev_idx = DRAMreadAddr[1:0];
      prev_wr = DRAMwriteEn;
      prev_wa = DRAMwriteAddr;
    end
  end

  // stimulus
  initial begin
    logic [63:0] w;
    int p;
    int n;
    rst = 1'b1;
    start = 1'b0;
    row_req = 1'b0;
    pool_valid = 1'b0;
    pool_data = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    tick();
    rst = 1'b0;

    // Pass 1: credit saturation, then reset in the middle of a row.
    rd_cnt = 0;
    for (int i = 0; i < 20; i++) exp_rd_q.push_back(ADDR_W'(i));
    pulse_start_and_check();
    tick();
    row_req = 1'b1;
    tick();
    row_req = 1'b0;
    wait_rd(10'd0, 20);
    tick();
    row_req = 1'b1;
    tick();
    tick();
    tick();
    row_req = 1'b0;
    wait_rd(10'd4, 20);
    tick();
    row_req = 1'b1;
    tick();
    tick();
    row_req = 1'b0;
    repeat (60) @(negedge clk);
    chk("saturated_rows_reads", rd_cnt, 20);
    chk("saturated_rows_queue", exp_rd_q.size(), 0);
    for (int i = 20; i < 24; i++) exp_rd_q.push_back(ADDR_W'(i));
    tick();
    row_req = 1'b1;
    tick();
    row_req = 1'b0;
    wait_rd(10'd21, 20);
    tick();
    rst = 1'b1;
    #1;
    chk_all_zero("midpass_reset");
    exp_rd_q.delete();
    tick();
    tick();
    rst = 1'b0;
    tick();
    row_req = 1'b1;
    tick();
    tick();
    row_req = 1'b0;
    repeat (20) @(negedge clk);
    chk("no_done_after_abort", done_cnt, 0);
    chk("idle_after_abort", {63'd0, busy}, 64'd0);
    chk("reads_before_abort", rd_cnt, 22);

    // Pass 2: full fetch, packing, collisions, overflow pixels, start while busy.
    pool_valid = 1'b1;
    pool_data = 8'hAA;
    tick();
    tick();
    pool_valid = 1'b0;
    rd_cnt = 0;
    wr_cnt = 0;
    pl_cnt = 0;
    for (int i = 0; i < 112; i++) exp_rd_q.push_back(ADDR_W'(i));
    for (int wi = 0; wi < 25; wi++) begin
      w = '0;
      for (int b = 0; b < 8; b++) begin
        p = wi * 8 + b;
        if (p < 196) w[b*8 +: 8] = 8'(p);
      end
      exp_wa_q.push_back(ADDR_W'(wi));
      exp_wd_q.push_back(w);
    end
    pulse_start_and_check();
    repeat (10) @(negedge clk);
    chk("no_reads_without_credit", rd_cnt, 0);
    fork
      begin : req_driver
        int sent = 0;
        int m = 0;
        for (int k = 0; k < 3; k++) begin
          tick();
          row_req = 1'b1;
          sent++;
        end
        tick();
        row_req = 1'b0;
        while (sent < 28 && m < 2000) begin
          @(negedge clk);
          m++;
          if (ifmap_valid && ifmap_word_idx == 2'd3) begin
            tick();
            row_req = 1'b1;
            tick();
            row_req = 1'b0;
            sent++;
          end
        end
        chk("row_req_sent", sent, 28);
      end
      begin : pix_driver
        for (int i = 0; i < 200; i++) begin
          tick();
          pool_valid = 1'b1;
          pool_data = 8'(i);
          start = (i == 100);
          if (i % 2 == 1) begin
            tick();
            pool_valid = 1'b0;
            start = 1'b0;
          end
        end
        tick();
        pool_valid = 1'b0;
        start = 1'b0;
      end
    join
    n = 0;
    while (done_cnt == 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", done_cnt, 1);
    repeat (5) @(negedge clk);
    chk("done_once", done_cnt, 1);
    chk("busy_after_done", {63'd0, busy}, 64'd0);
    chk("total_reads", rd_cnt, 112);
    chk("total_writes", wr_cnt, 25);
    chk("read_queue_drained", exp_rd_q.size(), 0);
    chk("write_queue_drained", exp_wa_q.size(), 0);
    chk("single_param_load", pl_cnt, 1);
    chk("word0", word0, 64'h0706050403020100);
    chk("word24", word24, 64'h00000000C3C2C1C0);
    chk("write_took_port_from_reads", {63'd0, (wr_overlap != 0)}, 64'd1);
    tick();
    pool_valid = 1'b1;
    pool_data = 8'h55;
    tick();
    tick();
    pool_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("idle_pixels_ignored", wr_cnt, 25);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
